// File: rtl/alarm_timekeeper.sv
// -----------------------------------------------------------------------------
// alarm_timekeeper
//
// This is a BCD time-of-day core. Hours run 00-23, and every time value is
// packed two-digit BCD. The core has NUM_ALARMS programmable alarm channels, a
// ring state machine with a timeout and an acknowledge, and an optional
// top-of-hour pre-chime.
//
// Ports
//   CP              system clock, rising edge
//   CR              asynchronous active-high reset
//   TICK            1 Hz enable pulse, one CP cycle wide
//   CE              count enable (gates TICK for timekeeping only)
//   PE              load strobe for D_H/D_M/D_S (has priority over TICK)
//   D_H/D_M/D_S     BCD load value
//   Q_H/Q_M/Q_S     BCD current time
//   TC_S/TC_M/TC_H  one-cycle rollover pulses
//   LD_ERR          one-cycle pulse when a load is rejected
//   AL_WE/AL_SEL    alarm register write strobe / channel index
//   AL_H/AL_M/AL_EN alarm time and arm bit to be written
//   AL_ACK          stop ringing
//   RING/RING_ID    alarm sounding / channels that caused the current ring
//   CHIME           high for the last five seconds of every hour
// -----------------------------------------------------------------------------
module alarm_timekeeper #(
  parameter int NUM_ALARMS = 4,
  parameter int RING_SECS  = 30,
  parameter int CHIME_EN   = 1,
  localparam int SEL_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  CP,
  input  logic                  CR,
  input  logic                  TICK,
  input  logic                  CE,
  input  logic                  PE,
  input  logic [7:0]            D_H,
  input  logic [7:0]            D_M,
  input  logic [7:0]            D_S,
  output logic [7:0]            Q_H,
  output logic [7:0]            Q_M,
  output logic [7:0]            Q_S,
  output logic                  TC_S,
  output logic                  TC_M,
  output logic                  TC_H,
  output logic                  LD_ERR,
  input  logic                  AL_WE,
  input  logic [SEL_W-1:0]      AL_SEL,
  input  logic [7:0]            AL_H,
  input  logic [7:0]            AL_M,
  input  logic                  AL_EN,
  input  logic                  AL_ACK,
  output logic                  RING,
  output logic [NUM_ALARMS-1:0] RING_ID,
  output logic                  CHIME
);

  localparam logic [7:0] RING_LIM = 8'(RING_SECS);

  // Add one to a valid two-digit BCD value. The caller handles wrap-around.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Both digits must be 0-9, and the packed value must not exceed the limit.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= lim);
  endfunction

  // ---------------------------------------------------------------------------
  // Time-of-day counter
  // ---------------------------------------------------------------------------
  logic [7:0] h_reg, m_reg, s_reg, h_next, m_next, s_next;
  logic       tc_s_reg, tc_m_reg, tc_h_reg, tc_s_next, tc_m_next, tc_h_next;
  logic       ld_err_reg, ld_err_next;
  logic       s_wrap, m_wrap, h_wrap, tick_ok, load_ok;
  logic [7:0] h_cnt, m_cnt, s_cnt;

  assign s_wrap  = (s_reg == 8'h59);
  assign m_wrap  = s_wrap && (m_reg == 8'h59);
  assign h_wrap  = m_wrap && (h_reg == 8'h23);
  assign s_cnt   = s_wrap ? 8'h00 : bcd_inc(s_reg);
  assign m_cnt   = s_wrap ? ((m_reg == 8'h59) ? 8'h00 : bcd_inc(m_reg)) : m_reg;
  assign h_cnt   = m_wrap ? ((h_reg == 8'h23) ? 8'h00 : bcd_inc(h_reg)) : h_reg;
  // A load in the same cycle drops the tick, so the tick cannot cause a match.
  assign tick_ok = TICK && CE && !PE;
  assign load_ok = bcd_ok(D_H, 8'h23) && bcd_ok(D_M, 8'h59) && bcd_ok(D_S, 8'h59);

  always_comb begin
    h_next      = h_reg;
    m_next      = m_reg;
    s_next      = s_reg;
    tc_s_next   = 1'b0;
    tc_m_next   = 1'b0;
    tc_h_next   = 1'b0;
    ld_err_next = 1'b0;
    if (PE) begin
      if (load_ok) begin
        h_next = D_H;
        m_next = D_M;
        s_next = D_S;
      end else begin
        ld_err_next = 1'b1;
      end
    end else if (tick_ok) begin
      h_next    = h_cnt;
      m_next    = m_cnt;
      s_next    = s_cnt;
      tc_s_next = s_wrap;
      tc_m_next = m_wrap;
      tc_h_next = h_wrap;
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      h_reg      <= 8'h00;
      m_reg      <= 8'h00;
      s_reg      <= 8'h00;
      tc_s_reg   <= 1'b0;
      tc_m_reg   <= 1'b0;
      tc_h_reg   <= 1'b0;
      ld_err_reg <= 1'b0;
    end else begin
      h_reg      <= h_next;
      m_reg      <= m_next;
      s_reg      <= s_next;
      tc_s_reg   <= tc_s_next;
      tc_m_reg   <= tc_m_next;
      tc_h_reg   <= tc_h_next;
      ld_err_reg <= ld_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm registers and match detection
  // ---------------------------------------------------------------------------
  logic [7:0]            al_h_reg [NUM_ALARMS];
  logic [7:0]            al_m_reg [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] al_en_reg;
  logic [NUM_ALARMS-1:0] match_vec;

  // Indices at or above NUM_ALARMS match no channel, so those writes are lost.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      al_en_reg <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        al_h_reg[i] <= 8'h00;
        al_m_reg[i] <= 8'h00;
      end
    end else if (AL_WE) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (AL_SEL == SEL_W'(i)) begin
          al_h_reg[i]  <= AL_H;
          al_m_reg[i]  <= AL_M;
          al_en_reg[i] <= AL_EN;
        end
      end
    end
  end

  // A match happens only on a counted tick that lands on HH:MM:00. The compare
  // is made against the incremented time. That time is always valid BCD, so an
  // alarm stored with invalid BCD never fires.
  for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_match
    assign match_vec[gi] = tick_ok && s_wrap && al_en_reg[gi] &&
                           (al_h_reg[gi] == h_cnt) && (al_m_reg[gi] == m_cnt);
  end

  // ---------------------------------------------------------------------------
  // Ring FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {ST_IDLE, ST_RINGING} ring_state_t;

  ring_state_t           state_reg, state_next;
  logic [7:0]            cnt_reg, cnt_next;
  logic [NUM_ALARMS-1:0] id_reg, id_next;

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'd0;
      id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      id_reg    <= id_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    id_next    = id_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|match_vec) begin
          state_next = ST_RINGING;
          cnt_next   = 8'd0;
          id_next    = match_vec;
        end
      end
      ST_RINGING: begin
        // A new match outranks both acknowledge and timeout and restarts the ring.
        if (|match_vec) begin
          cnt_next = 8'd0;
          id_next  = id_reg | match_vec;
        end else if (AL_ACK) begin
          state_next = ST_IDLE;
          cnt_next   = 8'd0;
          id_next    = '0;
        end else if (TICK) begin
          // The ring duration counts raw ticks, so it keeps running while CE is low.
          if (cnt_reg + 8'd1 == RING_LIM) begin
            state_next = ST_IDLE;
            cnt_next   = 8'd0;
            id_next    = '0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 8'd0;
        id_next    = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Q_H     = h_reg;
  assign Q_M     = m_reg;
  assign Q_S     = s_reg;
  assign TC_S    = tc_s_reg;
  assign TC_M    = tc_m_reg;
  assign TC_H    = tc_h_reg;
  assign LD_ERR  = ld_err_reg;
  assign RING    = (state_reg == ST_RINGING);
  assign RING_ID = id_reg;

  if (CHIME_EN != 0) begin : g_chime
    assign CHIME = (m_reg == 8'h59) && (s_reg >= 8'h55) && (s_reg <= 8'h59);
  end else begin : g_no_chime
    assign CHIME = 1'b0;
  end

endmodule

// File: tb/tb_alarm_timekeeper.sv
// -----------------------------------------------------------------------------
// tb_alarm_timekeeper
//
// This bench drives directed vectors and checks them against expected values
// worked out by hand. A second instance is built with CHIME_EN=0. It shares
// all inputs with the main instance and checks that its CHIME output stays low.
// -----------------------------------------------------------------------------
module tb_alarm_timekeeper;

  logic       CP = 1'b0;
  logic       CR, TICK, CE, PE, AL_WE, AL_EN, AL_ACK;
  logic [7:0] D_H, D_M, D_S, AL_H, AL_M;
  logic [1:0] AL_SEL;
  logic [7:0] Q_H, Q_M, Q_S;
  logic       TC_S, TC_M, TC_H, LD_ERR, RING, CHIME;
  logic [3:0] RING_ID;

  logic [7:0] q_h_b, q_m_b, q_s_b;
  logic       tc_s_b, tc_m_b, tc_h_b, ld_err_b, ring_b, chime_b;
  logic [3:0] ring_id_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CP = ~CP;

  alarm_timekeeper #(.NUM_ALARMS(4), .RING_SECS(30), .CHIME_EN(1)) dut (
    .CP(CP), .CR(CR), .TICK(TICK), .CE(CE), .PE(PE),
    .D_H(D_H), .D_M(D_M), .D_S(D_S),
    .Q_H(Q_H), .Q_M(Q_M), .Q_S(Q_S),
    .TC_S(TC_S), .TC_M(TC_M), .TC_H(TC_H), .LD_ERR(LD_ERR),
    .AL_WE(AL_WE), .AL_SEL(AL_SEL), .AL_H(AL_H), .AL_M(AL_M), .AL_EN(AL_EN),
    .AL_ACK(AL_ACK), .RING(RING), .RING_ID(RING_ID), .CHIME(CHIME)
  );

  alarm_timekeeper #(.NUM_ALARMS(4), .RING_SECS(30), .CHIME_EN(0)) dut_nochime (
    .CP(CP), .CR(CR), .TICK(TICK), .CE(CE), .PE(PE),
    .D_H(D_H), .D_M(D_M), .D_S(D_S),
    .Q_H(q_h_b), .Q_M(q_m_b), .Q_S(q_s_b),
    .TC_S(tc_s_b), .TC_M(tc_m_b), .TC_H(tc_h_b), .LD_ERR(ld_err_b),
    .AL_WE(AL_WE), .AL_SEL(AL_SEL), .AL_H(AL_H), .AL_M(AL_M), .AL_EN(AL_EN),
    .AL_ACK(AL_ACK), .RING(ring_b), .RING_ID(ring_id_b), .CHIME(chime_b)
  );

  wire [23:0] q_all  = {Q_H, Q_M, Q_S};
  wire [2:0]  tc_all = {TC_H, TC_M, TC_S};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Inputs change 1 time unit after the rising edge. Outputs are sampled there too.
  task automatic cycle();
    @(posedge CP);
    #1;
  endtask

  task automatic tick();
    TICK = 1'b1;
    cycle();
    TICK = 1'b0;
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    PE = 1'b1; D_H = h; D_M = m; D_S = s;
    cycle();
    PE = 1'b0;
  endtask

  task automatic wr_al(input logic [1:0] sel, input logic [7:0] h, input logic [7:0] m,
                       input logic en);
    AL_WE = 1'b1; AL_SEL = sel; AL_H = h; AL_M = m; AL_EN = en;
    cycle();
    AL_WE = 1'b0;
  endtask

  initial begin
    CR = 1'b1; TICK = 1'b0; CE = 1'b1; PE = 1'b0; AL_WE = 1'b0; AL_EN = 1'b0;
    AL_ACK = 1'b0; D_H = 8'h00; D_M = 8'h00; D_S = 8'h00; AL_H = 8'h00;
    AL_M = 8'h00; AL_SEL = 2'd0;
    repeat (2) cycle();

    // Reset state
    check("rst_q", q_all, 24'h000000);
    check("rst_tc", tc_all, 3'b000);
    check("rst_lderr", LD_ERR, 1'b0);
    check("rst_ring", {RING, RING_ID}, 5'b0);
    check("rst_chime", CHIME, 1'b0);
    CR = 1'b0;
    cycle();

    // Midnight rollover
    load(8'h23, 8'h59, 8'h58);
    check("load_235958", q_all, 24'h235958);
    tick();
    check("tick_235959", q_all, 24'h235959);
    check("tc_none", tc_all, 3'b000);
    tick();
    check("tick_000000", q_all, 24'h000000);
    check("tc_all", tc_all, 3'b111);
    cycle();
    check("tc_one_cycle", tc_all, 3'b000);

    // Rejected loads
    load(8'h24, 8'h00, 8'h00);
    check("bad_h_err", LD_ERR, 1'b1);
    check("bad_h_q", q_all, 24'h000000);
    cycle();
    check("lderr_one_cycle", LD_ERR, 1'b0);
    load(8'h12, 8'h00, 8'h5A);
    check("bad_s_err", LD_ERR, 1'b1);
    check("bad_s_q", q_all, 24'h000000);

    // A load wins over a tick in the same cycle
    TICK = 1'b1;
    load(8'h12, 8'h00, 8'h00);
    TICK = 1'b0;
    check("pe_tick_q", q_all, 24'h120000);
    check("pe_tick_lderr", LD_ERR, 1'b0);

    // CE low holds time
    CE = 1'b0;
    tick();
    check("ce0_hold", q_all, 24'h120000);
    CE = 1'b1;

    // Alarms: ch0 and ch2 armed at 07:30, ch1 armed at 07:31, ch3 at 07:30 disarmed
    wr_al(2'd0, 8'h07, 8'h30, 1'b1);
    wr_al(2'd1, 8'h07, 8'h31, 1'b1);
    wr_al(2'd2, 8'h07, 8'h30, 1'b1);
    wr_al(2'd3, 8'h07, 8'h30, 1'b0);
    load(8'h07, 8'h29, 8'h59);
    check("preload_noring", RING, 1'b0);
    tick();
    check("match_q", q_all, 24'h073000);
    check("match_ring", RING, 1'b1);
    check("match_id", RING_ID, 4'b0101);
    for (int i = 0; i < 29; i++) tick();
    check("ring_29", RING, 1'b1);
    tick();
    check("ring_timeout", RING, 1'b0);
    check("ring_timeout_id", RING_ID, 4'b0000);

    // Acknowledge
    load(8'h07, 8'h29, 8'h59);
    tick();
    check("ring2_on", RING, 1'b1);
    AL_ACK = 1'b1;
    cycle();
    AL_ACK = 1'b0;
    check("ack_off", {RING, RING_ID}, 5'b0);

    // Acknowledge together with a new match restarts the ring
    load(8'h07, 8'h29, 8'h59);
    tick();
    check("ring3_id", RING_ID, 4'b0101);
    wr_al(2'd0, 8'h07, 8'h30, 1'b0);
    check("disarm_keeps_ring", RING, 1'b1);
    repeat (4) tick();
    load(8'h07, 8'h30, 8'h59);
    check("load_keeps_ring", RING, 1'b1);
    AL_ACK = 1'b1;
    tick();
    AL_ACK = 1'b0;
    check("ack_match_q", q_all, 24'h073100);
    check("ack_match_ring", RING, 1'b1);
    check("ack_match_id", RING_ID, 4'b0111);
    for (int i = 0; i < 29; i++) tick();
    check("restart_29", RING, 1'b1);
    tick();
    check("restart_timeout", RING, 1'b0);

    // Disarmed channels do not ring, and a direct load does not ring
    wr_al(2'd2, 8'h07, 8'h30, 1'b0);
    load(8'h07, 8'h29, 8'h59);
    tick();
    check("disarmed_q", q_all, 24'h073000);
    check("disarmed_noring", RING, 1'b0);
    load(8'h07, 8'h31, 8'h00);
    check("load_match_noring", RING, 1'b0);
    check("load_no_tc", tc_all, 3'b000);

    // Pre-chime
    load(8'h10, 8'h59, 8'h54);
    check("chime_54", CHIME, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("chime_5%0d", 5 + i), CHIME, 1'b1);
      check($sformatf("nochime_5%0d", 5 + i), chime_b, 1'b0);
    end
    tick();
    check("chime_q_110000", q_all, 24'h110000);
    check("chime_top", CHIME, 1'b0);

    // Asynchronous reset while ringing
    load(8'h07, 8'h30, 8'h59);
    tick();
    check("ring4_id", RING_ID, 4'b0010);
    CR = 1'b1;
    #2;
    check("cr_ring", {RING, RING_ID}, 5'b0);
    check("cr_q", q_all, 24'h000000);
    cycle();
    CR = 1'b0;
    cycle();
    load(8'h07, 8'h30, 8'h59);
    tick();
    check("cr_alarms_cleared", RING, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
